// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx among NUM_REQ byte producers with round-robin grant.
//   A granted byte is latched, then the transmitter is walked through
//   wait-ready -> start pulse -> wait-done, and the requester is told when its
//   byte was taken (o_Ack) and when its frame ended (o_Done). A watchdog
//   aborts WAIT_DONE if o_TX_Done never shows up.
// Ports
//   i_Clock, i_Rst_L     clock, async active-low reset (sync release upstream)
//   i_Req[NUM_REQ]       level requests, sampled only in IDLE
//   i_Byte[8*NUM_REQ]    requester k byte on [8k+7:8k]
//   o_Ack / o_Done       one-hot single-cycle pulses to the requesters
//   o_Timeout            pulses with o_Done when the watchdog fired
//   o_TX_DV, o_TX_Byte   to uart_tx
//   i_TX_Active/Done     from uart_tx
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 8192
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Byte,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic                 o_Timeout,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [WD_W-1:0]  WD_SAT  = {WD_W{1'b1}};
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_START      = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                tmo_flag_q, tmo_flag_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                tmo_q, tmo_d;
  logic                dv_q, dv_d;
  logic [7:0]          byte_q, byte_d;

  logic                found;
  logic [IDX_W-1:0]    pick;

  // Round-robin pick: first set request scanning up from ptr+1, wrapping.
  // ptr+i never exceeds 2*NUM_REQ-1, so one extra bit and a single
  // conditional subtract implements the modulo for any NUM_REQ.
  always_comb begin
    logic [IDX_W:0] c;
    c     = '0;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (c >= (IDX_W+1)'(NUM_REQ)) c = c - (IDX_W+1)'(NUM_REQ);
      if (!found && i_Req[c[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = c[IDX_W-1:0];
      end
    end
  end

  // State register plus datapath flops
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_RST;
      gnt_q      <= '0;
      wd_q       <= '0;
      tmo_flag_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      tmo_q      <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      wd_q       <= wd_d;
      tmo_flag_q <= tmo_flag_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (found) state_d = S_WAIT_READY;
      S_WAIT_READY: if (!i_TX_Active) state_d = S_START;
      S_START:      state_d = S_WAIT_DONE;
      S_WAIT_DONE:  if (i_TX_Done || (wd_q == WD_LAST)) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath; pulses default low every cycle
  always_comb begin
    ack_d      = '0;
    done_d     = '0;
    tmo_d      = 1'b0;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d       = pick;
          byte_d      = i_Byte[{pick, 3'b000} +: 8];
          ack_d[pick] = 1'b1;
        end
      end
      S_START: begin
        dv_d = 1'b1;
        wd_d = '0;
      end
      S_WAIT_DONE: begin
        if (wd_q != WD_SAT) wd_d = wd_q + 1'b1;
        // A real done in the same cycle wins over the watchdog
        if (!i_TX_Done && (wd_q == WD_LAST)) tmo_flag_d = 1'b1;
      end
      S_DONE: begin
        done_d[gnt_q] = 1'b1;
        tmo_d         = tmo_flag_q;
        ptr_d         = gnt_q;
        tmo_flag_d    = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_Ack     = ack_q;
  assign o_Done    = done_q;
  assign o_Timeout = tmo_q;
  assign o_TX_DV   = dv_q;
  assign o_TX_Byte = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter model, frame monitor,
// expected (requester, byte) scoreboard, one task per scenario.
module tb_uart_tx_arbiter;
  localparam int N      = 4;
  localparam int TMO    = 64;
  localparam int FRAME  = 40;
  localparam int BUDGET = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [8*N-1:0]   bytes;
  logic [N-1:0]     o_Ack, o_Done;
  logic             o_Timeout, o_TX_DV;
  logic [7:0]       o_TX_Byte;
  logic             m_active, m_done, tb_busy, no_done;
  logic             tx_active;
  logic [2*N+9:0]   outs;
  int               m_cnt;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;

  typedef struct {
    int         ack_cyc;
    int         idx;
    int         dv_cyc;
    logic [7:0] data;
    int         txd_cyc;
    int         done_cyc;
    int         done_idx;
    logic       tmo;
  } frame_t;
  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  frame_t cur;
  frame_t frame_q[$];
  exp_t   exp_q[$];

  assign tx_active = m_active | tb_busy;
  assign outs      = {o_Ack, o_Done, o_Timeout, o_TX_DV, o_TX_Byte};

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Req(req), .i_Byte(bytes),
    .o_Ack(o_Ack), .o_Done(o_Done), .o_Timeout(o_Timeout),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .i_TX_Active(tx_active), .i_TX_Done(m_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy FRAME clocks after a start pulse, then done
  // (suppressed when no_done is set). Shares the reset like uart_tx does.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (o_TX_DV) begin
        m_active <= 1'b1; m_cnt <= FRAME - 1;
      end else if (m_active) begin
        if (m_cnt == 0) begin
          m_active <= 1'b0; m_done <= !no_done;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Frame monitor: stamps each event with the clock edge that produced it
  always @(negedge clk) begin
    if (|o_Ack) begin
      cur = '{default: 0};
      cur.ack_cyc = cyc; cur.idx = oh2i(o_Ack);
      checks++;
      if ($countones(o_Ack) != 1 || |o_Done) begin
        errors++;
        $display("FAIL ack_onehot: ack %b done %b, need one-hot ack and no done", o_Ack, o_Done);
      end
    end
    if (o_TX_DV) begin cur.dv_cyc = cyc; cur.data = o_TX_Byte; end
    if (m_done) cur.txd_cyc = cyc;
    if (o_Timeout && !(|o_Done)) begin
      checks++; errors++;
      $display("FAIL timeout_alone: o_Timeout=1 with o_Done=%b", o_Done);
    end
    if (|o_Done) begin
      cur.done_cyc = cyc; cur.done_idx = oh2i(o_Done); cur.tmo = o_Timeout;
      checks++;
      if ($countones(o_Done) != 1 || o_TX_Byte !== cur.data) begin
        errors++;
        $display("FAIL done_onehot: done %b byte %h, need one-hot done and byte %h", o_Done, o_TX_Byte, cur.data);
      end
      frame_q.push_back(cur);
    end
  end

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (|o_Ack) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (frame_q.size() >= n) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; bytes = '0; tb_busy = 1'b0; no_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h, need 0", outs); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_outs: got %h, need 0", outs); end
  endtask

  task automatic test_round_robin();
    bit ok; frame_t f; exp_t e;
    frame_q.delete(); exp_q.delete();
    for (int k = 0; k < N; k++) bytes[8*k +: 8] = 8'h41 + 8'(k);
    for (int k = 0; k < 5; k++) exp_q.push_back('{k % N, 8'h41 + 8'(k % N)});
    req = '1;
    for (int k = 0; k < 5; k++) begin wait_ack(ok); if (!ok) break; end
    req = '0;
    wait_frames(5, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rr_wait: got %0d frames, need 5", frame_q.size());
      return;
    end
    for (int k = 0; k < 5; k++) begin
      f = frame_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (f.idx !== e.idx || f.data !== e.data || f.done_idx !== e.idx) begin
        errors++;
        $display("FAIL rr_frame%0d: got req %0d byte %h done %0d, need req %0d byte %h",
                 k, f.idx, f.data, f.done_idx, e.idx, e.data);
      end
    end
  endtask

  task automatic test_single();
    bit ok; frame_t f; exp_t e;
    frame_q.delete(); exp_q.delete();
    bytes[7:0] = 8'h46; exp_q.push_back('{0, 8'h46});
    req = 4'b0001;
    wait_ack(ok);
    req = '0;
    wait_frames(1, ok);
    if (!ok) begin checks++; errors++; $display("FAIL single_wait: no frame, need 1"); return; end
    f = frame_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (f.idx !== e.idx || f.data !== e.data) begin
      errors++; $display("FAIL single_grant: got req %0d byte %h, need req %0d byte %h", f.idx, f.data, e.idx, e.data);
    end
    checks++;
    if (f.dv_cyc - f.ack_cyc !== 2) begin
      errors++; $display("FAIL single_dv_lat: got %0d, need 2", f.dv_cyc - f.ack_cyc);
    end
    checks++;
    if (f.done_cyc - f.txd_cyc !== 2) begin
      errors++; $display("FAIL single_done_lat: got %0d, need 2", f.done_cyc - f.txd_cyc);
    end
    checks++;
    if (f.done_idx !== 0 || f.tmo !== 1'b0) begin
      errors++; $display("FAIL single_done: got done %0d tmo %b, need done 0 tmo 0", f.done_idx, f.tmo);
    end
  endtask

  task automatic test_fairness();
    bit ok; frame_t f; exp_t e;
    frame_q.delete(); exp_q.delete();
    bytes[7:0] = 8'h30; bytes[23:16] = 8'h32;
    exp_q.push_back('{0, 8'h30}); exp_q.push_back('{2, 8'h32}); exp_q.push_back('{0, 8'h30});
    req = 4'b0001;
    wait_ack(ok);
    req[2] = 1'b1;
    wait_ack(ok);
    req[2] = 1'b0;
    wait_ack(ok);
    req[0] = 1'b0;
    wait_frames(3, ok);
    if (!ok) begin checks++; errors++; $display("FAIL fair_wait: got %0d frames, need 3", frame_q.size()); return; end
    for (int k = 0; k < 3; k++) begin
      f = frame_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (f.idx !== e.idx || f.data !== e.data) begin
        errors++;
        $display("FAIL fair_frame%0d: got req %0d byte %h, need req %0d byte %h", k, f.idx, f.data, e.idx, e.data);
      end
    end
  endtask

  task automatic test_busy();
    bit ok; bit dv_seen; int fall; frame_t f;
    frame_q.delete();
    bytes[31:24] = 8'h5A;
    req = 4'b1000;
    wait_ack(ok);
    req = '0;
    tb_busy = 1'b1;
    dv_seen = 1'b0;
    repeat (200) begin @(negedge clk); if (o_TX_DV) dv_seen = 1'b1; end
    checks++;
    if (dv_seen) begin errors++; $display("FAIL busy_hold: o_TX_DV rose while busy, need 0"); end
    tb_busy = 1'b0; fall = cyc;
    wait_frames(1, ok);
    if (!ok) begin checks++; errors++; $display("FAIL busy_wait: no frame, need 1"); return; end
    f = frame_q.pop_front();
    checks++;
    if (f.dv_cyc - fall !== 2 || f.idx !== 3 || f.data !== 8'h5A) begin
      errors++;
      $display("FAIL busy_release: got dv lat %0d req %0d byte %h, need 2 3 5a", f.dv_cyc - fall, f.idx, f.data);
    end
  endtask

  task automatic test_watchdog();
    bit ok; frame_t f;
    frame_q.delete();
    no_done = 1'b1;
    bytes[15:8] = 8'h77;
    req = 4'b0010;
    wait_ack(ok);
    req = '0;
    wait_frames(1, ok);
    no_done = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL wd_wait: no frame, need 1"); return; end
    f = frame_q.pop_front();
    checks++;
    if (f.tmo !== 1'b1 || f.done_idx !== 1) begin
      errors++; $display("FAIL wd_flag: got tmo %b done %0d, need tmo 1 done 1", f.tmo, f.done_idx);
    end
    checks++;
    if (f.done_cyc - f.dv_cyc !== TMO + 1) begin
      errors++; $display("FAIL wd_lat: got %0d, need %0d", f.done_cyc - f.dv_cyc, TMO + 1);
    end
    bytes[23:16] = 8'h88;
    req = 4'b0100;
    wait_ack(ok);
    req = '0;
    wait_frames(1, ok);
    if (!ok) begin checks++; errors++; $display("FAIL wd_next_wait: no frame, need 1"); return; end
    f = frame_q.pop_front();
    checks++;
    if (f.tmo !== 1'b0 || f.idx !== 2 || f.data !== 8'h88 || f.done_cyc - f.txd_cyc !== 2) begin
      errors++;
      $display("FAIL wd_next: got tmo %b req %0d byte %h lat %0d, need 0 2 88 2", f.tmo, f.idx, f.data, f.done_cyc - f.txd_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; bit extra; frame_t f;
    // Complete one frame for requester 1 so the pointer sits at 1
    frame_q.delete();
    bytes[15:8] = 8'h11;
    req = 4'b0010;
    wait_ack(ok);
    req = '0;
    wait_frames(1, ok);
    if (!ok) begin checks++; errors++; $display("FAIL rst_pre_wait: no frame, need 1"); return; end
    f = frame_q.pop_front();
    checks++;
    if (f.idx !== 1 || f.data !== 8'h11) begin
      errors++; $display("FAIL rst_pre: got req %0d byte %h, need 1 11", f.idx, f.data);
    end
    // Second frame for requester 1, aborted by reset inside WAIT_DONE
    frame_q.delete(); exp_q.delete();
    bytes[15:8] = 8'h22; bytes[23:16] = 8'h33;
    req = 4'b0010;
    wait_ack(ok);
    req = 4'b0110;
    for (int i = 0; i < BUDGET; i++) begin @(negedge clk); if (o_TX_DV) break; end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rst_async: got %h, need 0", outs); end
    repeat (3) @(negedge clk);
    checks++;
    if (frame_q.size() != 0) begin errors++; $display("FAIL rst_no_done: got %0d done, need 0", frame_q.size()); end
    rst_n = 1'b1;
    exp_q.push_back('{1, 8'h22});
    wait_ack(ok);
    checks++;
    if (!ok || o_Ack !== 4'b0010) begin
      errors++; $display("FAIL rst_first_grant: got ack %b, need 0010", o_Ack);
    end
    req = '0;
    wait_frames(1, ok);
    if (!ok) begin checks++; errors++; $display("FAIL rst_post_wait: no frame, need 1"); return; end
    f = frame_q.pop_front();
    checks++;
    if (f.idx !== exp_q[0].idx || f.data !== exp_q[0].data || f.tmo !== 1'b0) begin
      errors++; $display("FAIL rst_post: got req %0d byte %h tmo %b, need 1 22 0", f.idx, f.data, f.tmo);
    end
    void'(exp_q.pop_front());
    extra = 1'b0;
    repeat (20) begin @(negedge clk); if (|o_Ack) extra = 1'b1; end
    checks++;
    if (extra) begin errors++; $display("FAIL rst_withdraw: got ack after withdraw, need none"); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_fairness();
    test_busy();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
